// File: rtl/inv_sub_bytes_iter.sv
// Iterative AES InvSubBytes engine.
// A 128-bit state is accepted over a valid/ready handshake. LANES bytes are
// replaced by InvSbox(b) each cycle, and the finished state is then presented
// over a valid/ready output handshake. Byte 0 is the MSB (FIPS-197 order).
module inv_sub_bytes_iter #(
  parameter int LANES = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data
);

  localparam int GROUPS = 16 / LANES;
  localparam int CW     = (GROUPS > 1) ? $clog2(GROUPS) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  // Reject lane counts that do not divide the state into whole groups.
  if (!(LANES == 1 || LANES == 2 || LANES == 4 || LANES == 8 || LANES == 16)) begin : g_bad_lanes
    $error("inv_sub_bytes_iter: LANES must be 1, 2, 4, 8 or 16");
  end

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [127:0]  st;
  logic [127:0]  st_next;

  // GF(2^8) multiply modulo x^8+x^4+x^3+x+1.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Inverse S-box: inverse affine map, then multiplicative inverse as y^254
  // (which maps 0 to 0, matching the AES convention).
  function automatic logic [7:0] inv_sbox(input logic [7:0] b);
    logic [7:0] y;
    logic [7:0] p;
    logic [7:0] r;
    y = {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
    p = y;
    r = 8'h01;
    // 254 = 2+4+8+16+32+64+128: multiply together the successive squares.
    for (int i = 0; i < 7; i++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r;
  endfunction

  // Substitute the current group of LANES bytes; all other bytes hold.
  always_comb begin
    // NOTE: full default before the loop so no path leaves st_next unassigned (no latch).
    st_next = st;
    for (int l = 0; l < LANES; l++) begin
      int idx;
      idx = int'(cnt) * LANES + l;
      st_next[127 - 8*idx -: 8] = inv_sbox(st[127 - 8*idx -: 8]);
    end
  end

  // Control FSM and working state.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      st    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            st    <= in_data;
            cnt   <= '0;
            state <= BUSY;
          end
        end
        BUSY: begin
          st <= st_next;
          if (cnt == CW'(GROUPS - 1)) begin
            cnt   <= '0;
            state <= DONE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign out_data  = st;

endmodule

// File: tb/tb_inv_sub_bytes_iter.sv
// Self-checking bench for inv_sub_bytes_iter.
// One instance per legal LANES value; each has its own driver, scoreboard
// queue and monitor. The reference is a lookup table obtained by building the
// forward S-box from first principles and inverting it.
module tb_inv_sub_bytes_iter;

  typedef struct {
    logic [127:0] data;
    int           acc;
  } item_t;

  logic clk = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  logic [7:0] fwd_tab [256];
  logic [7:0] inv_tab [256];

  always #5 clk = ~clk;

  // Free-running cycle count used to measure latency.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input int lanes, input string name,
                       input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL L%0d_%s actual=%h required=%h", lanes, name, act, exp);
    end
  endtask

  function automatic logic [7:0] m_mul(input logic [7:0] a, input logic [7:0] b);
    int acc;
    int aa;
    acc = 0;
    aa  = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ aa;
      aa = aa << 1;
      if (aa >= 256) aa = aa ^ 'h11b;
    end
    return acc[7:0];
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
    logic [15:0] t;
    t = {b, b} << n;
    return t[15:8];
  endfunction

  function automatic logic [127:0] model(input logic [127:0] d);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[127 - 8*i -: 8] = inv_tab[d[127 - 8*i -: 8]];
    return r;
  endfunction

  for (genvar k = 0; k < 5; k++) begin : g
    localparam int L = 1 << k;

    logic         rst;
    logic         iv;
    logic         ir;
    logic         ov;
    logic         ordy;
    logic [127:0] id;
    logic [127:0] od;
    bit           done = 1'b0;
    item_t        q[$];

    inv_sub_bytes_iter #(.LANES(L)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (iv),
      .in_ready  (ir),
      .in_data   (id),
      .out_valid (ov),
      .out_ready (ordy),
      .out_data  (od)
    );

    task automatic send_exp(input logic [127:0] d, input logic [127:0] e);
      int    n;
      item_t it;
      iv = 1'b1;
      id = d;
      n  = 0;
      while (!ir && n < 300) begin
        @(negedge clk);
        n++;
      end
      if (!ir) begin
        check(L, "accept_timeout", ir, 1);
        iv = 1'b0;
      end else begin
        it.data = e;
        it.acc  = cyc + 1;
        q.push_back(it);
        @(negedge clk);
        // Keep in_valid high with junk data: it must not matter while busy.
        id = {$urandom, $urandom, $urandom, $urandom};
      end
    endtask

    // Driver: reset, abort, known vector with backpressure, constants,
    // full round trip, random back-to-back.
    initial begin
      int n;
      rst  = 1'b1;
      iv   = 1'b0;
      id   = '0;
      ordy = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      check(L, "reset_in_ready", ir, 1);
      check(L, "reset_out_valid", ov, 0);
      check(L, "reset_out_data", od, 0);

      // Abort a transaction mid-flight; nothing must come out for it.
      iv = 1'b1;
      id = {16{8'h63}};
      @(negedge clk);
      iv  = 1'b0;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      check(L, "abort_in_ready", ir, 1);
      check(L, "abort_out_valid", ov, 0);
      check(L, "abort_out_data", od, 0);

      // Known vector, held under backpressure for 10 cycles.
      ordy = 1'b0;
      send_exp(128'h000102030405060708090a0b0c0d0e0f,
               128'h52096ad53036a538bf40a39e81f3d7fb);
      iv = 1'b0;
      n  = 0;
      while (!ov && n < 40) begin
        @(negedge clk);
        n++;
      end
      for (int c = 0; c < 10; c++) begin
        @(negedge clk);
        check(L, "bp_out_valid", ov, 1);
        check(L, "bp_in_ready", ir, 0);
        check(L, "bp_out_data", od, 128'h52096ad53036a538bf40a39e81f3d7fb);
        iv = c[0];
        id = {$urandom, $urandom, $urandom, $urandom};
      end
      iv   = 1'b0;
      ordy = 1'b1;
      @(negedge clk);
      ordy = 1'b0;
      @(negedge clk);
      check(L, "bp_release_in_ready", ir, 1);
      check(L, "bp_release_out_valid", ov, 0);
      ordy = 1'b1;

      // Constant states.
      send_exp({16{8'h63}}, {16{8'h00}});
      send_exp({16{8'h16}}, {16{8'hff}});
      send_exp({16{8'hed}}, {16{8'h53}});

      // Round trip through the forward S-box for every byte value.
      for (int x = 0; x < 256; x++) begin
        logic [7:0] xb;
        xb = x[7:0];
        send_exp({16{fwd_tab[xb]}}, {16{xb}});
      end

      // Random states, back-to-back.
      for (int r = 0; r < 20; r++) begin
        logic [127:0] d;
        d = {$urandom, $urandom, $urandom, $urandom};
        send_exp(d, model(d));
      end
      iv = 1'b0;

      n = 0;
      while (q.size() != 0 && n < 300) begin
        @(negedge clk);
        n++;
      end
      check(L, "queue_drained", 128'(q.size()), 0);
      done = 1'b1;
    end

    // Monitor: compares every presented result against the scoreboard head.
    initial begin
      bit    prev_ov;
      bit    hs;
      item_t it;
      prev_ov = 1'b0;
      hs      = 1'b0;
      forever begin
        @(negedge clk);
        #1;
        if (hs) begin
          check(L, "post_hs_out_valid", ov, 0);
          check(L, "post_hs_in_ready", ir, 1);
        end
        hs = 1'b0;
        if (ov) begin
          check(L, "done_in_ready", ir, 0);
          if (q.size() == 0) begin
            check(L, "spurious_out_valid", ov, 0);
          end else begin
            if (!prev_ov) check(L, "latency", 128'(cyc - q[0].acc), 128'(16 / L));
            check(L, "out_data", od, q[0].data);
            if (ordy) begin
              it = q.pop_front();
              hs = 1'b1;
            end
          end
        end
        prev_ov = ov;
      end
    end
  end

  // Build reference tables, wait for every lane to finish, report.
  initial begin
    int n;
    for (int a = 0; a < 256; a++) begin
      logic [7:0] b;
      b = 8'h00;
      for (int z = 1; z < 256; z++) begin
        if (m_mul(a[7:0], z[7:0]) == 8'h01) b = z[7:0];
      end
      fwd_tab[a] = b ^ rotl(b, 1) ^ rotl(b, 2) ^ rotl(b, 3) ^ rotl(b, 4) ^ 8'h63;
    end
    for (int a = 0; a < 256; a++) inv_tab[fwd_tab[a]] = a[7:0];

    n = 0;
    while (!(g[0].done && g[1].done && g[2].done && g[3].done && g[4].done) && n < 90000) begin
      @(posedge clk);
      n++;
    end
    check(0, "all_lanes_done",
          {g[4].done, g[3].done, g[2].done, g[1].done, g[0].done}, 5'h1f);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
